// File: rtl/regfile_pkg.sv
// Shared definitions for the 32-entry integer register file and the blocks around it.
//   REG_NUM    : number of architectural integer registers
//   REG_AW     : register address width
//   reg_addr_t : register address type
//   ZERO_REG   : hard-wired zero register address (x0)
package regfile_pkg;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_AW  = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter for one register's pending-write count.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear, overrides inc/dec
//   inc_i, dec_i  : count up / down; both together leave the count unchanged
//   cnt_o         : current count
//   is_zero_o     : count == 0
//   is_max_o      : count == 2^CNT_W - 1
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             is_zero_o,
    output logic             is_max_o
);

    localparam logic [CNT_W-1:0] MaxVal = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign is_zero_o = (cnt_q == '0);
    assign is_max_o  = (cnt_q == MaxVal);
    assign cnt_o     = cnt_q;

    // Saturate at both ends so a stray inc/dec can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !is_max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !is_zero_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard for the integer register file. Counts in-flight writes per
// destination register between issue and writeback and stalls ID on a RAW hazard or when
// a destination's counter is saturated.
// Ports:
//   dclk, rst_n            : clock, asynchronous active-low reset
//   issue_valid_i/we_i/rd_i: instruction presented by ID and its destination
//   rs1_re_i/addr_i        : source 1 read enable / address
//   rs2_re_i/addr_i        : source 2 read enable / address
//   wb_we_i/addr_i         : writeback of a register this cycle
//   flush_i                : drop every pending entry
//   stall_ID_o             : combinational; ID holds and the issue is not accepted
//   inflight_o             : registered total of pending writes
//   err_o                  : registered, sticky; writeback to a register with nothing pending
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic       dclk,
    input  logic       rst_n,
    input  logic       issue_valid_i,
    input  logic       issue_we_i,
    input  logic [4:0] issue_rd_i,
    input  logic       rs1_re_i,
    input  logic [4:0] rs1_addr_i,
    input  logic       rs2_re_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_addr_i,
    input  logic       flush_i,
    output logic       stall_ID_o,
    output logic [6:0] inflight_o,
    output logic       err_o
);

    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] dec_vec;
    logic [REG_NUM-1:0] is_zero;
    logic [REG_NUM-1:0] is_max;
    logic [CNT_W-1:0]   cnt [REG_NUM];

    logic haz_rs1, haz_rs2, haz_full;
    logic accept, inc_any, dec_any, err_set;

    logic [6:0] inflight_q, inflight_d;
    logic       err_q, err_d;

    // x0 has no storage: always zero, never full.
    assign cnt[0]     = '0;
    assign is_zero[0] = 1'b1;
    assign is_max[0]  = 1'b0;
    assign inc_vec[0] = 1'b0;
    assign dec_vec[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        assign inc_vec[r] = inc_any && (issue_rd_i == reg_addr_t'(r));
        assign dec_vec[r] = dec_any && (wb_addr_i == reg_addr_t'(r));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i     (dclk),
            .rst_ni    (rst_n),
            .clr_i     (flush_i),
            .inc_i     (inc_vec[r]),
            .dec_i     (dec_vec[r]),
            .cnt_o     (cnt[r]),
            .is_zero_o (is_zero[r]),
            .is_max_o  (is_max[r])
        );
    end

    // No writeback bypass: the register file read is registered, so a register stays
    // hazardous through its own writeback cycle.
    assign haz_rs1 = rs1_re_i && (rs1_addr_i != ZERO_REG) && !is_zero[rs1_addr_i];
    assign haz_rs2 = rs2_re_i && (rs2_addr_i != ZERO_REG) && !is_zero[rs2_addr_i];

    // A saturated destination may still issue if the same register is retiring one now.
    assign haz_full = issue_valid_i && issue_we_i && (issue_rd_i != ZERO_REG)
                      && is_max[issue_rd_i] && !(wb_we_i && (wb_addr_i == issue_rd_i));

    assign stall_ID_o = issue_valid_i && (haz_rs1 || haz_rs2 || haz_full);
    assign accept     = issue_valid_i && !stall_ID_o;

    assign inc_any = accept && issue_we_i && (issue_rd_i != ZERO_REG);
    assign dec_any = wb_we_i && (wb_addr_i != ZERO_REG) && !is_zero[wb_addr_i];
    assign err_set = wb_we_i && (wb_addr_i != ZERO_REG) && is_zero[wb_addr_i];

    always_comb begin
        inflight_d = inflight_q + {6'b0, inc_any} - {6'b0, dec_any};
        if (flush_i) begin
            inflight_d = '0;
        end
        // The error check is independent of flush.
        err_d = err_q || err_set;
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight_o = inflight_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int MAXC = 3;

    logic       dclk = 1'b0;
    logic       rst_n;
    logic       issue_valid_i, issue_we_i;
    logic [4:0] issue_rd_i;
    logic       rs1_re_i, rs2_re_i;
    logic [4:0] rs1_addr_i, rs2_addr_i;
    logic       wb_we_i;
    logic [4:0] wb_addr_i;
    logic       flush_i;
    logic       stall_ID_o;
    logic [6:0] inflight_o;
    logic       err_o;

    reg_scoreboard #(
        .CNT_W (2)
    ) dut (
        .dclk          (dclk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid_i),
        .issue_we_i    (issue_we_i),
        .issue_rd_i    (issue_rd_i),
        .rs1_re_i      (rs1_re_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_re_i      (rs2_re_i),
        .rs2_addr_i    (rs2_addr_i),
        .wb_we_i       (wb_we_i),
        .wb_addr_i     (wb_addr_i),
        .flush_i       (flush_i),
        .stall_ID_o    (stall_ID_o),
        .inflight_o    (inflight_o),
        .err_o         (err_o)
    );

    always #5 dclk = ~dclk;

    int tests = 0;
    int fails = 0;

    // Reference model: pending count per register and the sticky error.
    int m_cnt [32];
    int m_err;

    // Values sampled in the most recent step, for hand-computed checks.
    int s_stall, s_inflight, s_err;

    function automatic int m_inflight();
        int s = 0;
        for (int i = 0; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    endtask

    task automatic drive_idle();
        issue_valid_i = 0; issue_we_i = 0; issue_rd_i = 0;
        rs1_re_i = 0; rs1_addr_i = 0; rs2_re_i = 0; rs2_addr_i = 0;
        wb_we_i = 0; wb_addr_i = 0; flush_i = 0;
    endtask

    // One cycle: drive at negedge, compare DUT against the model, then advance the model
    // to what the following posedge must produce.
    task automatic step(input logic v, input logic we, input logic [4:0] rd,
                        input logic r1e, input logic [4:0] a1,
                        input logic r2e, input logic [4:0] a2,
                        input logic wbe, input logic [4:0] wba, input logic fl);
        int  exp_stall;
        bit  acc, dec_ok;
        @(negedge dclk);
        issue_valid_i = v; issue_we_i = we; issue_rd_i = rd;
        rs1_re_i = r1e; rs1_addr_i = a1; rs2_re_i = r2e; rs2_addr_i = a2;
        wb_we_i = wbe; wb_addr_i = wba; flush_i = fl;
        #1;
        exp_stall = (v && ((r1e && a1 != 0 && m_cnt[a1] > 0) ||
                           (r2e && a2 != 0 && m_cnt[a2] > 0) ||
                           (we && rd != 0 && m_cnt[rd] == MAXC && !(wbe && wba == rd)))) ? 1 : 0;
        check("stall", int'(stall_ID_o), exp_stall);
        check("inflight", int'(inflight_o), m_inflight());
        check("err", int'(err_o), m_err);
        s_stall = int'(stall_ID_o); s_inflight = int'(inflight_o); s_err = int'(err_o);

        acc    = v && (exp_stall == 0);
        dec_ok = wbe && wba != 0 && m_cnt[wba] > 0;
        if (wbe && wba != 0 && m_cnt[wba] == 0) m_err = 1;
        if (fl) begin
            model_clear();
        end else begin
            if (dec_ok) m_cnt[wba]--;
            if (acc && we && rd != 0) m_cnt[rd]++;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_w(input logic [4:0] rd);
        step(1, 1, rd, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [4:0] a);
        step(0, 0, 0, 0, 0, 0, 0, 1, a, 0);
    endtask

    task automatic do_reset();
        @(negedge dclk);
        drive_idle();
        rst_n = 0;
        model_clear();
        m_err = 0;
        #3;
        rst_n = 1;
    endtask

    initial begin
        drive_idle();
        rst_n = 0;
        model_clear();
        m_err = 0;
        #12;
        rst_n = 1;

        // Reset state, read of x5 with nothing pending.
        step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        check("rst_stall", s_stall, 0);
        check("rst_inflight", s_inflight, 0);
        check("rst_err", s_err, 0);

        // RAW hazard on x5 and its clearing by writeback (no bypass).
        issue_w(5);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("raw_stall", s_stall, 1);
        check("raw_inflight", s_inflight, 1);
        step(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        check("raw_wb_cycle_stall", s_stall, 1);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("raw_after_wb_stall", s_stall, 0);
        check("raw_after_wb_inflight", s_inflight, 0);

        // Saturation on x7, then issue accepted with a same-cycle writeback.
        issue_w(7); issue_w(7); issue_w(7);
        issue_w(7);
        check("full_stall", s_stall, 1);
        check("full_inflight", s_inflight, 3);
        step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
        check("full_wb_accept", s_stall, 0);
        idle();
        check("full_wb_inflight", s_inflight, 3);
        wb(7); wb(7); wb(7);
        idle();
        check("drain_inflight", s_inflight, 0);
        check("drain_err", s_err, 0);

        // x0 is ignored; writeback to an idle register raises a sticky error.
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        check("x0_stall", s_stall, 0);
        idle();
        check("x0_inflight", s_inflight, 0);
        wb(9);
        idle();
        check("err_set", s_err, 1);
        idle(); idle();
        check("err_sticky", s_err, 1);

        // Flush with a same-cycle issue.
        do_reset();
        issue_w(3); issue_w(4);
        idle();
        check("pre_flush_inflight", s_inflight, 2);
        step(1, 1, 6, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 3, 1, 4, 0, 0, 0);
        check("post_flush_inflight", s_inflight, 0);
        check("post_flush_stall34", s_stall, 0);
        step(1, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        check("post_flush_stall6", s_stall, 0);

        // Asynchronous reset between edges.
        issue_w(1); issue_w(2); issue_w(3); issue_w(4);
        @(posedge dclk);
        #2;
        drive_idle();
        issue_valid_i = 1; rs1_re_i = 1; rs1_addr_i = 1;
        #1;
        check("async_pre_inflight", int'(inflight_o), 4);
        check("async_pre_stall", int'(stall_ID_o), 1);
        rst_n = 0;
        #1;
        check("async_inflight", int'(inflight_o), 0);
        check("async_err", int'(err_o), 0);
        check("async_stall", int'(stall_ID_o), 0);
        model_clear();
        m_err = 0;
        @(negedge dclk);
        rst_n = 1;

        // Randomized traffic against the model, with a reset halfway to clear the error.
        for (int n = 0; n < 800; n++) begin
            logic       v, we, r1e, r2e, wbe, fl;
            logic [4:0] rd, a1, a2, wba;
            int         pend [$];
            if (n == 400) do_reset();
            v   = ($urandom % 4) != 0;
            we  = $urandom % 2;
            rd  = 5'($urandom % 8);
            r1e = $urandom % 2;
            a1  = 5'($urandom % 8);
            r2e = $urandom % 2;
            a2  = 5'($urandom % 8);
            wbe = ($urandom % 3) == 0;
            pend.delete();
            for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) pend.push_back(i);
            if (pend.size() > 0 && ($urandom % 8) != 0)
                wba = 5'(pend[$urandom % pend.size()]);
            else
                wba = 5'($urandom % 8);
            fl = ($urandom % 60) == 0;
            step(v, we, rd, r1e, a1, r2e, a2, wbe, wba, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
